enode_fire_scheduler: RTL

- Per-E-node issue controller that sits between the node's reservation-station frames and its single ALU.
- Each cycle it picks one eligible frame (operands complete, inside the active T-morph partition) by round-robin and issues it to the ALU with a valid/ready handshake.
- It waits for ALU completion, then pulses a one-hot frame clear back to the station.
- Frames whose predicate resolved false are nullified without using the ALU; a block flush aborts or drains in-flight work.

---
 rtl/enode_fire_scheduler_pkg.sv | 22 ++
 rtl/enode_fire_scheduler_frame_rr_arbiter.sv | 30 +++
 rtl/enode_fire_scheduler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/enode_fire_scheduler_pkg.sv
// Shared types and constants for the E-node fire scheduler.
// Default frame count is 8; override via the FRAMES parameter of the top module.
package enode_fire_scheduler_pkg;

    localparam int FRAMES_DEF = 8;
    localparam int FRAME_W = $clog2(FRAMES_DEF);
    localparam int STAT_W  = 16;

    typedef enum logic [1:0] {
        SCHED_IDLE,
        SCHED_ISSUE,
        SCHED_EXEC,
        SCHED_DRAIN
    } sched_state_t;

    typedef logic [FRAME_W-1:0] frame_idx_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/enode_fire_scheduler_frame_rr_arbiter.sv
// Combinational round-robin picker: first requesting frame at or above ptr, wrapping.
module frame_rr_arbiter #(
    parameter int FRAMES = 8,
    parameter int FW     = $clog2(FRAMES)
) (
    input  logic [FRAMES-1:0] req,
    input  logic [FW-1:0]     ptr,
    output logic              gnt_valid,
    output logic [FW-1:0]     gnt_idx,
    output logic [FRAMES-1:0] gnt
);

    logic [FW-1:0] cand;

    // Scan offsets from highest to lowest so the smallest offset wins last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = FRAMES - 1; i >= 0; i--) begin
            cand = ptr + FW'(i);
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
        gnt = gnt_valid ? (FRAMES'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/enode_fire_scheduler.sv
// Per-E-node issue controller: round-robin frame pick, ALU handshake, clear/nullify, flush.
// Optional ISSUE_STATS_EN adds saturating issue/nullify/stall counters.
module enode_fire_scheduler
    import enode_fire_scheduler_pkg::*;
#(
    parameter int FRAMES = FRAMES_DEF,
    parameter int FW     = $clog2(FRAMES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [FRAMES-1:0] frame_ready,
    input  logic [FRAMES-1:0] frame_pred_fail,
    input  logic [FRAMES-1:0] frame_mask,
    input  logic              flush,
    output logic              issue_valid,
    output logic [FW-1:0]     issue_frame,
    input  logic              issue_ready,
    input  logic              alu_done,
    output logic              result_squash,
    output logic [FRAMES-1:0] frame_clear,
    output logic              nullify_valid,
`ifdef ISSUE_STATS_EN
    output logic [STAT_W-1:0] stat_issued,
    output logic [STAT_W-1:0] stat_nullified,
    output logic [STAT_W-1:0] stat_stall,
`endif
    output logic              busy
);

    sched_state_t      state_q, state_d;
    logic [FW-1:0]     gnt_q, gnt_d;
    logic [FW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [FRAMES-1:0] clear_q, clear_d;
    logic              nullify_q, nullify_d;

    logic [FRAMES-1:0] eligible;
    logic              arb_valid;
    logic [FW-1:0]     arb_idx;
    logic [FRAMES-1:0] arb_gnt;

    // A frame being cleared this cycle still shows ready until the station reacts.
    assign eligible = frame_ready & frame_mask & ~clear_q;

    frame_rr_arbiter #(.FRAMES(FRAMES), .FW(FW)) u_arb (
        .req       (eligible),
        .ptr       (rr_ptr_q),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx),
        .gnt       (arb_gnt)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        clear_d   = '0;
        nullify_d = 1'b0;
        unique case (state_q)
            SCHED_IDLE: begin
                if (!flush && enable && arb_valid) begin
                    rr_ptr_d = arb_idx + FW'(1);
                    if (frame_pred_fail[arb_idx]) begin
                        clear_d   = arb_gnt;
                        nullify_d = 1'b1;
                    end else begin
                        gnt_d   = arb_idx;
                        state_d = SCHED_ISSUE;
                    end
                end
            end
            SCHED_ISSUE: begin
                if (flush) begin
                    state_d = SCHED_IDLE;
                end else if (issue_ready) begin
                    if (alu_done) begin
                        clear_d = FRAMES'(1) << gnt_q;
                        state_d = SCHED_IDLE;
                    end else begin
                        state_d = SCHED_EXEC;
                    end
                end
            end
            SCHED_EXEC: begin
                if (flush) begin
                    state_d = alu_done ? SCHED_IDLE : SCHED_DRAIN;
                end else if (alu_done) begin
                    clear_d = FRAMES'(1) << gnt_q;
                    state_d = SCHED_IDLE;
                end
            end
            SCHED_DRAIN: begin
                if (alu_done) state_d = SCHED_IDLE;
            end
            default: state_d = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SCHED_IDLE;
            gnt_q     <= '0;
            rr_ptr_q  <= '0;
            clear_q   <= '0;
            nullify_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_ptr_q  <= rr_ptr_d;
            clear_q   <= clear_d;
            nullify_q <= nullify_d;
        end
    end

    assign issue_valid   = (state_q == SCHED_ISSUE);
    assign issue_frame   = issue_valid ? gnt_q : '0;
    assign result_squash = (state_q == SCHED_DRAIN);
    assign frame_clear   = clear_q;
    assign nullify_valid = nullify_q;
    assign busy          = (state_q != SCHED_IDLE);

`ifdef ISSUE_STATS_EN
    logic [STAT_W-1:0] stat_issued_q, stat_nullified_q, stat_stall_q;
    logic              accept_now;

    assign accept_now = issue_valid && issue_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued_q    <= '0;
            stat_nullified_q <= '0;
            stat_stall_q     <= '0;
        end else begin
            stat_issued_q    <= sat_inc(stat_issued_q, accept_now);
            stat_nullified_q <= sat_inc(stat_nullified_q, nullify_d);
            stat_stall_q     <= sat_inc(stat_stall_q, issue_valid && !issue_ready);
        end
    end

    assign stat_issued    = stat_issued_q;
    assign stat_nullified = stat_nullified_q;
    assign stat_stall     = stat_stall_q;
`endif

endmodule
